ps2_cmd_sequencer: RTL
======================

Name: ps2_cmd_sequencer

Overview:
- Host-to-keyboard command controller. Sits between the keyboard scancode decoder and the altera_up_ps2 core.
- Drives the core's the_command/send_command inputs to run two sequences:
  - keyboard reset/BAT check;
  - LED update (0xED + LED byte).
- Consumes the keyboard's response bytes (0xFA ACK, 0xFE resend, 0xAA BAT pass, 0xFC BAT fail) and retries on failure.
- Forwards all other received bytes unchanged to the scancode decoder.

Parameters:
- ACK_TIMEOUT, 1000000, clk50 cycles to wait for ACK after a byte is sent (20 ms at 50 MHz).
- BAT_TIMEOUT, 50000000, clk50 cycles to wait for 0xAA/0xFC after the 0xFF ACK (1 s).
- MAX_RETRY, 3, resends per byte before abort.
- POWERUP_INIT, 1, 1 = run the reset sequence automatically after rst deasserts.

Ports:
- clk50  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- init_req  in  1  one-cycle pulse: start reset sequence (0xFF)
- led_req  in  1  one-cycle pulse: start LED update
- led_state  in  3  {caps,num,scroll}, sampled when led_req is accepted
- the_command  out  8  byte to the PS/2 core
- send_command  out  1  send strobe to the PS/2 core (level)
- command_was_sent  in  1  core: byte transmitted
- error_communication_timed_out  in  1  core: transmit failed
- received_data  in  8  core: received byte
- received_data_en  in  1  core: one-cycle valid for received_data
- scan_data  out  8  forwarded scancode byte
- scan_valid  out  1  one-cycle valid for scan_data
- busy  out  1  sequence in progress
- kbd_ok  out  1  last reset sequence passed BAT
- err  out  1  sticky: abort occurred; cleared by the next accepted request

Behaviour:
- Reset values: the_command=0x00, send_command=0, scan_data=0x00, scan_valid=0, busy=0, kbd_ok=0, err=0; state=IDLE; pending flags cleared.
- The async rst aborts any sequence immediately. If POWERUP_INIT=1, init_pending=1 on reset release.
- Request latching:
  - init_req and led_req each set a one-deep pending flag, in any state.
  - IDLE serves init before LED.
  - led_state is captured into led_byte when the LED request is served; a new led_req while pending overwrites the captured value at service time.
- States and transitions:
  - IDLE: if a request is pending, load the byte (0xFF, or 0xED), clear that pending flag and err, set busy=1 -> SEND.
  - SEND: the_command=byte, send_command=1. Stay here until command_was_sent (-> WAIT_ACK, send_command=0, timer cleared) or error_communication_timed_out (-> RETRY, send_command=0).
  - WAIT_ACK: timer counts up. On received_data_en:
    - 0xFA -> NEXT;
    - 0xFE -> RETRY;
    - any other byte is forwarded, state unchanged.
    - timer==ACK_TIMEOUT-1 -> RETRY.
  - RETRY: if retry_cnt<MAX_RETRY, retry_cnt++ -> GAP (same byte). Otherwise err=1; if sending 0xFF, kbd_ok=0 -> IDLE.
  - GAP: 2-cycle send_command=0 gap -> SEND.
  - NEXT: retry_cnt=0.
    - After 0xFF -> WAIT_BAT.
    - After 0xED -> load led_byte={5'b0,caps,num,scroll} -> GAP.
    - After the LED byte -> IDLE.
  - WAIT_BAT:
    - 0xAA -> kbd_ok=1 -> IDLE.
    - 0xFC -> kbd_ok=0, err=1 -> IDLE.
    - timer==BAT_TIMEOUT-1 -> kbd_ok=0, err=1 -> IDLE.
- busy: 1 in every state except IDLE; 0 one cycle after return to IDLE.
- Forwarding:
  - In IDLE and GAP, every received byte is forwarded.
  - In WAIT_ACK and WAIT_BAT, 0xFA/0xFE/0xAA/0xFC are consumed and all others are forwarded.
  - In SEND, received bytes are forwarded.
  - Forwarding latency is 1 cycle: scan_data registered, scan_valid pulses for 1 cycle.
- Timers are 26-bit counters and saturate; they never wrap.
- retry_cnt is per byte and reset on each new byte.
- If command_was_sent and error_communication_timed_out arrive in the same cycle, the error wins (-> RETRY).
- If received_data_en arrives in the same cycle as the timeout expiry, the byte wins.

Optional Feature:
- PS2_CAPS_TRACK_EN defined:
  - An internal caps/num/scroll register (reset 000) tracks the keyboard lock keys.
  - A forwarded 0x58 not preceded by 0xF0 toggles caps; 0x77 toggles num; 0x7E toggles scroll.
  - Each toggle raises an internal LED request that uses the internal register instead of led_state. External led_req is still honoured.
- PS2_CAPS_TRACK_EN undefined: LEDs change only through led_req/led_state; no prefix tracking logic.

Test Plan:
- POWERUP_INIT=1, release rst; model sends 0xFA, then 0xAA -> the_command=0xFF with one send burst, busy=1 throughout, then kbd_ok=1, busy=0, err=0; no scan_valid pulses.
- led_req with led_state=3'b101; model ACKs both bytes -> sends 0xED then 0x05 in order; busy falls after the second ACK.
- led_req; model answers 0xFE twice, then 0xFA -> 0xED sent 3 times; each resend preceded by ≥2 cycles of send_command=0; sequence completes, err=0.
- led_req; model never ACKs (ACK_TIMEOUT=100 in test) -> 4 sends of 0xED (initial + MAX_RETRY), then err=1, busy=0; the LED byte is never sent.
- During WAIT_ACK, inject 0x1C then 0xFA -> scan_data=0x1C with a one-cycle scan_valid, 0xFA not forwarded, sequence advances.
- init_req and led_req in the same cycle -> reset sequence (0xFF) runs first, then 0xED; assert rst mid-SEND -> send_command=0, busy=0 on the same edge.

Source files
------------

// File: rtl/ps2_cmd_sequencer_if.sv
//==============================================================================
// Module      : ps2_cmd_sequencer_if
// Description : Command/response link between the command sequencer and the
//               altera_up_ps2 core.
// Revision    : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface ps2_cmd_sequencer_if;
    logic [7:0] the_command;
    logic       send_command;
    logic       command_was_sent;
    logic       error_communication_timed_out;
    logic [7:0] received_data;
    logic       received_data_en;

    modport master (
        output the_command,
        output send_command,
        input  command_was_sent,
        input  error_communication_timed_out,
        input  received_data,
        input  received_data_en
    );

    modport slave (
        input  the_command,
        input  send_command,
        output command_was_sent,
        output error_communication_timed_out,
        output received_data,
        output received_data_en
    );
endinterface

`default_nettype wire

// File: rtl/ps2_cmd_sequencer.sv
//==============================================================================
// Module      : ps2_cmd_sequencer
// Description : PS/2 host-to-keyboard command controller (reset/BAT and LED
//               update sequences with retry). Optional lock-key tracking is
//               enabled by defining PS2_CAPS_TRACK_EN.
// Revision    : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_cmd_sequencer #(
    parameter int ACK_TIMEOUT  = 1000000,
    parameter int BAT_TIMEOUT  = 50000000,
    parameter int MAX_RETRY    = 3,
    parameter int POWERUP_INIT = 1
) (
    input  wire logic              clk50,
    input  wire logic              rst,
    input  wire logic              init_req,
    input  wire logic              led_req,
    input  wire logic [2:0]        led_state,
    ps2_cmd_sequencer_if.master    core,
    output logic      [7:0]        scan_data,
    output logic                   scan_valid,
    output logic                   busy,
    output logic                   kbd_ok,
    output logic                   err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SEND     = 3'd1;
    localparam logic [2:0] S_WAIT_ACK = 3'd2;
    localparam logic [2:0] S_RETRY    = 3'd3;
    localparam logic [2:0] S_GAP      = 3'd4;
    localparam logic [2:0] S_NEXT     = 3'd5;
    localparam logic [2:0] S_WAIT_BAT = 3'd6;

    localparam logic [7:0]  c_cmd_reset = 8'hFF;
    localparam logic [7:0]  c_cmd_led   = 8'hED;
    localparam logic [7:0]  c_rsp_ack   = 8'hFA;
    localparam logic [7:0]  c_rsp_rsnd  = 8'hFE;
    localparam logic [7:0]  c_bat_pass  = 8'hAA;
    localparam logic [7:0]  c_bat_fail  = 8'hFC;
    localparam logic [25:0] c_ack_last  = 26'(ACK_TIMEOUT - 1);
    localparam logic [25:0] c_bat_last  = 26'(BAT_TIMEOUT - 1);
    localparam logic [25:0] c_tmr_max   = '1;
    localparam logic [7:0]  c_max_retry = 8'(MAX_RETRY);

    logic [2:0]  r_state;
    logic [7:0]  r_byte;
    logic [7:0]  r_led_byte;
    logic [7:0]  r_retry_cnt;
    logic [25:0] r_timer;
    logic        r_gap_cnt;
    logic        r_init_pend;
    logic        r_led_pend;

    logic        w_rx;
    logic        w_rsp_code;
    logic        w_fwd;
    logic        w_lock_hit;
    logic [2:0]  w_led_src;

    assign w_rx       = core.received_data_en;
    assign w_rsp_code = (core.received_data == c_rsp_ack)  || (core.received_data == c_rsp_rsnd) ||
                        (core.received_data == c_bat_pass) || (core.received_data == c_bat_fail);
    // Response codes are swallowed only while a response is actually expected.
    assign w_fwd      = w_rx && !(((r_state == S_WAIT_ACK) || (r_state == S_WAIT_BAT)) && w_rsp_code);

`ifdef PS2_CAPS_TRACK_EN
    logic [2:0] r_locks;
    logic       r_break;
    logic       r_led_int;
    logic [2:0] w_lock_flip;

    always_comb begin
        w_lock_flip = 3'b000;
        if (w_fwd && !r_break) begin
            case (core.received_data)
                8'h58:   w_lock_flip = 3'b100;
                8'h77:   w_lock_flip = 3'b010;
                8'h7E:   w_lock_flip = 3'b001;
                default: w_lock_flip = 3'b000;
            endcase
        end
    end

    assign w_lock_hit = |w_lock_flip;
    assign w_led_src  = r_led_int ? r_locks : led_state;

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            r_locks   <= 3'b000;
            r_break   <= 1'b0;
            r_led_int <= 1'b0;
        end else begin
            if (w_fwd) begin
                r_break <= (core.received_data == 8'hF0);
                r_locks <= r_locks ^ w_lock_flip;
            end
            if (w_lock_hit) r_led_int <= 1'b1;
            if (led_req)    r_led_int <= 1'b0;
        end
    end
`else
    assign w_lock_hit = 1'b0;
    assign w_led_src  = led_state;
`endif

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_byte            <= 8'h00;
            r_led_byte        <= 8'h00;
            r_retry_cnt       <= 8'h00;
            r_timer           <= 26'd0;
            r_gap_cnt         <= 1'b0;
            r_init_pend       <= (POWERUP_INIT != 0);
            r_led_pend        <= 1'b0;
            core.the_command  <= 8'h00;
            core.send_command <= 1'b0;
            scan_data         <= 8'h00;
            scan_valid        <= 1'b0;
            busy              <= 1'b0;
            kbd_ok            <= 1'b0;
            err               <= 1'b0;
        end else begin
            scan_valid <= w_fwd;
            if (w_fwd) scan_data <= core.received_data;

            case (r_state)
                S_IDLE: begin
                    if (r_init_pend || r_led_pend) begin
                        r_retry_cnt       <= 8'h00;
                        err               <= 1'b0;
                        busy              <= 1'b1;
                        core.send_command <= 1'b1;
                        r_state           <= S_SEND;
                        if (r_init_pend) begin
                            r_init_pend      <= 1'b0;
                            r_byte           <= c_cmd_reset;
                            core.the_command <= c_cmd_reset;
                        end else begin
                            r_led_pend       <= 1'b0;
                            r_byte           <= c_cmd_led;
                            core.the_command <= c_cmd_led;
                            r_led_byte       <= {5'b00000, w_led_src};
                        end
                    end
                end
                S_SEND: begin
                    if (core.error_communication_timed_out) begin
                        core.send_command <= 1'b0;
                        r_state           <= S_RETRY;
                    end else if (core.command_was_sent) begin
                        core.send_command <= 1'b0;
                        r_timer           <= 26'd0;
                        r_state           <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (r_timer != c_tmr_max) r_timer <= r_timer + 26'd1;
                    // A byte arriving on the expiry cycle defers the timeout.
                    if (w_rx) begin
                        if (core.received_data == c_rsp_ack)       r_state <= S_NEXT;
                        else if (core.received_data == c_rsp_rsnd) r_state <= S_RETRY;
                    end else if (r_timer >= c_ack_last) begin
                        r_state <= S_RETRY;
                    end
                end
                S_RETRY: begin
                    if (r_retry_cnt < c_max_retry) begin
                        r_retry_cnt <= r_retry_cnt + 8'h01;
                        r_gap_cnt   <= 1'b0;
                        r_state     <= S_GAP;
                    end else begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                        if (r_byte == c_cmd_reset) kbd_ok <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt) begin
                        core.the_command  <= r_byte;
                        core.send_command <= 1'b1;
                        r_state           <= S_SEND;
                    end else begin
                        r_gap_cnt <= 1'b1;
                    end
                end
                S_NEXT: begin
                    r_retry_cnt <= 8'h00;
                    if (r_byte == c_cmd_reset) begin
                        r_timer <= 26'd0;
                        r_state <= S_WAIT_BAT;
                    end else if (r_byte == c_cmd_led) begin
                        r_byte    <= r_led_byte;
                        r_gap_cnt <= 1'b0;
                        r_state   <= S_GAP;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT_BAT: begin
                    if (r_timer != c_tmr_max) r_timer <= r_timer + 26'd1;
                    if (w_rx && (core.received_data == c_bat_pass)) begin
                        kbd_ok  <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else if ((w_rx && (core.received_data == c_bat_fail)) ||
                                 (!w_rx && (r_timer >= c_bat_last))) begin
                        kbd_ok  <= 1'b0;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    core.send_command <= 1'b0;
                    busy              <= 1'b0;
                    r_state           <= S_IDLE;
                end
            endcase

            // Requests latch in any state and override a same-cycle service clear.
            if (init_req)               r_init_pend <= 1'b1;
            if (led_req || w_lock_hit)  r_led_pend  <= 1'b1;
        end
    end

endmodule

`default_nettype wire
